timer_counter: RTL

Memory-mapped programmable down-counter that acts as a hardware interrupt source for the CPU's coprocessor-0 interrupt logic. Software programs a preset value and a mode through the system bridge. The block counts down once per clock and raises `irq` on reaching zero. `irq` drives one bit of the CPU's 6-bit hardware-interrupt vector and is the requesting end of the interrupt path that CP0 samples, masks and services.

---
 rtl/timer_counter_if.sv | 16 +
 rtl/timer_counter.sv | 113 +++++++++++
 2 files changed

// File: rtl/timer_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_counter_if : register bus and interrupt line of the timer_counter
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface timer_counter_if;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (output addr, output we, output wdata, input rdata, input irq);
   modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_counter : memory-mapped programmable down-counter, interrupt source
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module timer_counter (
   input  wire logic       clk,
   input  wire logic       reset,
   timer_counter_if.slave  bus
);

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] MODE_RELOAD = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        flag_q, flag_d;

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;

      case (state_q)
         S_IDLE: begin
            if (ctrl_q[0]) state_d = S_LOAD;
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!ctrl_q[0]) begin
               state_d = S_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               // also covers a preset of 0, so it behaves like a preset of 1
               count_d = 32'd0;
               flag_d  = 1'b1;
               state_d = S_INT;
            end
         end
         S_INT: begin
            if (ctrl_q[2:1] == MODE_RELOAD) begin
               flag_d  = 1'b0;
               state_d = S_LOAD;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // bus writes come last so a CTRL write overrides the one-shot En clear
      if (bus.we) begin
         case (bus.addr)
            ADDR_CTRL: begin
               ctrl_d = bus.wdata[3:0];
               flag_d = 1'b0;
            end
            ADDR_PRESET: begin
               preset_d = bus.wdata;
               flag_d   = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ctrl_q   <= 4'd0;
         preset_q <= 32'd0;
         count_q  <= 32'd0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      case (bus.addr)
         ADDR_CTRL:   bus.rdata = {28'd0, ctrl_q};
         ADDR_PRESET: bus.rdata = preset_q;
         ADDR_COUNT:  bus.rdata = count_q;
         default:     bus.rdata = 32'd0;
      endcase
   end

   assign bus.irq = ctrl_q[3] & flag_q;

endmodule
`default_nettype wire
